sobol_seq_gen: RTL



---
 rtl/sobol_seq_gen_pkg.sv | 14 +
 rtl/sobol_seq_gen_if.sv | 29 ++
 rtl/sobol_seq_gen_lsz.sv | 22 ++
 rtl/sobol_seq_gen.sv | 85 ++++++++
 4 files changed

// File: rtl/sobol_seq_gen_pkg.sv
// Shared defaults for the Sobol generator and the reset value of its
// direction vectors.
package sobolrng_pkg;
  localparam int DEF_BITWIDTH    = 8;
  localparam int DEF_LOGBITWIDTH = $clog2(DEF_BITWIDTH);
  localparam int MAX_BITWIDTH    = 16;

  typedef logic [MAX_BITWIDTH-1:0] vec_max_t;

  // Dimension-1 (van der Corput) vector: V[k] = 1 << (w-1-k).
  function automatic vec_max_t dflt_dir(input int w, input int k);
    return vec_max_t'(1) << (w - 1 - k);
  endfunction
endpackage

// File: rtl/sobol_seq_gen_if.sv
// Config and output-stream bundle of the Sobol generator.
// The master side is the generator; the slave side is the consumer/config.
interface sobol_seq_gen_if
  import sobolrng_pkg::*;
#(
  parameter int BITWIDTH    = DEF_BITWIDTH,
  parameter int LOGBITWIDTH = $clog2(BITWIDTH)
);
  logic                   en;
  logic                   restart;
  logic                   dir_we;
  logic [LOGBITWIDTH-1:0] dir_idx;
  logic [BITWIDTH-1:0]    dir_data;
  logic [BITWIDTH-1:0]    out_data;
  logic [BITWIDTH-1:0]    out_idx;
  logic                   out_valid;
  logic                   out_ready;
  logic                   wrap;

  modport master (
    input  en, restart, dir_we, dir_idx, dir_data, out_ready,
    output out_data, out_idx, out_valid, wrap
  );

  modport slave (
    output en, restart, dir_we, dir_idx, dir_data, out_ready,
    input  out_data, out_idx, out_valid, wrap
  );
endinterface

// File: rtl/sobol_seq_gen_lsz.sv
// Least-significant-zero finder. An all-ones input has no zero: it
// reports index 0 and raises none_o.
module lsz_param
  import sobolrng_pkg::*;
#(
  parameter int BITWIDTH    = DEF_BITWIDTH,
  parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
  input  logic [BITWIDTH-1:0]    x_i,
  output logic [BITWIDTH-1:0]    onehot_o,
  output logic [LOGBITWIDTH-1:0] idx_o,
  output logic                   none_o
);
  assign onehot_o = ~x_i & (x_i + BITWIDTH'(1));
  assign none_o   = &x_i;

  always_comb begin
    idx_o = '0;
    for (int k = 0; k < BITWIDTH; k++)
      if (onehot_o[k]) idx_o = LOGBITWIDTH'(k);
  end
endmodule

// File: rtl/sobol_seq_gen.sv
// Gray-code Sobol generator for one dimension with loadable direction
// vectors and a valid/ready output stream.
module sobol_seq_gen
  import sobolrng_pkg::*;
#(
  parameter int BITWIDTH    = DEF_BITWIDTH,
  parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  sobol_seq_gen_if.master bus
);
  logic [BITWIDTH-1:0]               data_q, data_d;
  logic [BITWIDTH-1:0]               idx_q, idx_d;
  logic                              vld_q, vld_d;
  logic                              wrap_q, wrap_d;
  logic [BITWIDTH-1:0][BITWIDTH-1:0] v_q, v_d;

  logic [BITWIDTH-1:0]    lsz_oh;
  logic [LOGBITWIDTH-1:0] lsz_idx;
  logic                   lsz_none;
  logic                   fire;
  logic                   dir_ok;
  logic                   unused_oh;

  lsz_param #(.BITWIDTH(BITWIDTH), .LOGBITWIDTH(LOGBITWIDTH)) u_lsz (
    .x_i      (idx_q),
    .onehot_o (lsz_oh),
    .idx_o    (lsz_idx),
    .none_o   (lsz_none)
  );

  assign unused_oh = ^lsz_oh;
  assign fire      = vld_q & bus.out_ready;
  assign dir_ok    = int'(bus.dir_idx) < BITWIDTH;

  // Reads of v_q here see the pre-write vector, so a same-cycle write
  // never affects the point being produced.
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    wrap_d = 1'b0;
    v_d    = v_q;
    if (bus.dir_we && dir_ok) v_d[bus.dir_idx] = bus.dir_data;
    if (bus.restart) begin
      data_d = '0;
      idx_d  = '0;
      vld_d  = 1'b0;
    end else if (fire) begin
      vld_d = bus.en;
      idx_d = idx_q + BITWIDTH'(1);
      if (lsz_none) begin
        data_d = '0;
        wrap_d = 1'b1;
      end else begin
        data_d = data_q ^ v_q[lsz_idx];
      end
    end else if (!vld_q && bus.en) begin
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
      for (int k = 0; k < BITWIDTH; k++)
        v_q[k] <= BITWIDTH'(dflt_dir(BITWIDTH, k));
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      wrap_q <= wrap_d;
      v_q    <= v_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = vld_q;
  assign bus.wrap      = wrap_q;
endmodule
